// File: rtl/uart_rx.sv
// uart_rx: serial receiver for the SoC UART, configurable data bits and parity.
// The rx input is already synchronized to clk. Baud timing comes from a runtime
// clocks-per-bit value N that is latched at the start edge. Each bit is sampled
// once, near its centre; there is no oversampling.
module uart_rx #(
  parameter int DATA_BITS = 8,  // 5..9, sent LSB first
  parameter int PARITY    = 0   // 0 = none, 1 = even, 2 = odd
) (
  input  logic                 clk,
  input  logic                 reset,         // asynchronous, active low
  input  logic                 rx,
  input  logic [15:0]          clocksPerBit,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 busy
);

  localparam logic [2:0] ST_WAIT_HIGH = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       ODD_PAR  = (PARITY == 2);

  logic [2:0]           state;
  logic [15:0]          n_reg;      // bit period latched at the start edge
  logic [15:0]          cyc_cnt;    // counts down to the next sample point
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic [15:0]          n_eff;
  logic                 sample;
  logic                 parity_bad;

  // Bit periods shorter than 4 clocks are clamped so the half-period is at least 2.
  assign n_eff = (clocksPerBit < 16'd4) ? 16'd4 : clocksPerBit;

  // A sample point is reached when the down-counter hits zero.
  assign sample = (cyc_cnt == 16'd0);

  // Even parity: data and parity bit XOR to 0. Odd parity: they XOR to 1.
  assign parity_bad = ((^shift_reg) ^ par_bit) != ODD_PAR;

  // WAIT_HIGH and IDLE are the only states without a frame in progress.
  assign busy = (state != ST_WAIT_HIGH) && (state != ST_IDLE);

  // Receive state machine, bit timing and registered completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_WAIT_HIGH;
      n_reg       <= 16'd4;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      // NOTE: the shift register is reset too, so a discarded frame never leaks partial data.
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      dataOut     <= '0;
      dataValid   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
      dataValid   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;

      case (state)
        ST_WAIT_HIGH: begin
          if (rx) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (!rx) begin
            n_reg   <= n_eff;
            cyc_cnt <= (n_eff >> 1) - 16'd1;
            bit_cnt <= '0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (!sample) begin
            cyc_cnt <= cyc_cnt - 16'd1;
          end else if (rx) begin
            state <= ST_IDLE;  // too short to be a start bit
          end else begin
            cyc_cnt <= n_reg - 16'd1;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (!sample) begin
            cyc_cnt <= cyc_cnt - 16'd1;
          end else begin
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
            cyc_cnt   <= n_reg - 16'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (!sample) begin
            cyc_cnt <= cyc_cnt - 16'd1;
          end else begin
            par_bit <= rx;
            cyc_cnt <= n_reg - 16'd1;
            state   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (!sample) begin
            cyc_cnt <= cyc_cnt - 16'd1;
          end else begin
            dataOut <= shift_reg;
            if (rx) begin
              dataValid   <= 1'b1;
              parityError <= (PARITY != 0) && parity_bad;
              state       <= ST_IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= ST_WAIT_HIGH;  // a held-low break gives one error only
            end
          end
        end

        default: state <= ST_WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against three receiver configurations
// (8N1, 8 bits even parity, 7 bits odd parity). Expected pulse timing and contents
// are computed from frame arithmetic: ts = t0 + N/2 + (frame_bits-1)*N.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line [3];
  logic [15:0] cpb [3];
  logic [7:0]  dout0, dout1;
  logic [6:0]  dout2;
  logic [2:0]  dv, pe, fe, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;      // edge count; after edge E the value is E
  int busy_hi [3];

  typedef struct {
    int         unit;
    int         cyc;
    logic [8:0] data;
    logic       dv, pe, fe, busy;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_BITS(8), .PARITY(0)) u_rx0 (
    .clk(clk), .reset(rst_n), .rx(rx_line[0]), .clocksPerBit(cpb[0]), .dataOut(dout0),
    .dataValid(dv[0]), .parityError(pe[0]), .frameError(fe[0]), .busy(busy[0]));
  uart_rx #(.DATA_BITS(8), .PARITY(1)) u_rx1 (
    .clk(clk), .reset(rst_n), .rx(rx_line[1]), .clocksPerBit(cpb[1]), .dataOut(dout1),
    .dataValid(dv[1]), .parityError(pe[1]), .frameError(fe[1]), .busy(busy[1]));
  uart_rx #(.DATA_BITS(7), .PARITY(2)) u_rx2 (
    .clk(clk), .reset(rst_n), .rx(rx_line[2]), .clocksPerBit(cpb[2]), .dataOut(dout2),
    .dataValid(dv[2]), .parityError(pe[2]), .frameError(fe[2]), .busy(busy[2]));

  // Record every output pulse and count busy cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv[0] | pe[0] | fe[0]) evq.push_back(ev_t'{0, cyc, {1'b0, dout0}, dv[0], pe[0], fe[0], busy[0]});
    if (dv[1] | pe[1] | fe[1]) evq.push_back(ev_t'{1, cyc, {1'b0, dout1}, dv[1], pe[1], fe[1], busy[1]});
    if (dv[2] | pe[2] | fe[2]) evq.push_back(ev_t'{2, cyc, {2'b0, dout2}, dv[2], pe[2], fe[2], busy[2]});
    for (int i = 0; i < 3; i++) if (busy[i]) busy_hi[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the next recorded pulse and compare every field.
  task automatic expect_ev(input string tag, input int unit, input int cyc_e, input logic [8:0] d,
                           input logic v, input logic p, input logic f);
    ev_t e;
    if (evq.size() == 0) begin
      check({tag, "_present"}, evq.size(), 1);
      return;
    end
    e = evq.pop_front();
    check({tag, "_unit"}, e.unit, unit);
    check({tag, "_cycle"}, e.cyc, cyc_e);
    check({tag, "_data"}, e.data, d);
    check({tag, "_valid"}, e.dv, v);
    check({tag, "_parerr"}, e.pe, p);
    check({tag, "_frmerr"}, e.fe, f);
    check({tag, "_busy"}, e.busy, 1'b0);
  endtask

  // Line-level frame: start 0, data LSB first, optional parity, stop; bit 0 goes first.
  function automatic logic [31:0] make_frame(input logic [8:0] d, input int db, input int pm,
                                             input logic par, input logic stop, output int nb);
    logic [31:0] b = '1;
    int idx;
    b[0] = 1'b0;
    for (int i = 0; i < db; i++) b[1 + i] = d[i];
    idx = 1 + db;
    if (pm != 0) begin
      b[idx] = par;
      idx++;
    end
    b[idx] = stop;
    nb = idx + 1;
    return b;
  endfunction

  // Drive nb bits, each held n cycles; t0 is the edge that first sees bit 0.
  task automatic drive(input int idx, input int n, input logic [31:0] bits, input int nb,
                       input logic final_lvl, output int t0);
    @(posedge clk);
    #1;
    rx_line[idx] = bits[0];
    t0 = cyc + 1;
    for (int i = 1; i < nb; i++) begin
      repeat (n) @(posedge clk);
      #1;
      rx_line[idx] = bits[i];
    end
    repeat (n) @(posedge clk);
    #1;
    rx_line[idx] = final_lvl;
  endtask

  int          t0, t0b, nb, nb2, u, n, neff, db, pm;
  logic [8:0]  data, dmask;
  logic        par, good_par, stop;
  logic [31:0] bits, bits2;

  initial begin
    rx_line[0] = 1'b0;  // line held low through reset: must not start a frame
    rx_line[1] = 1'b1;
    rx_line[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpb[i]     = 16'd16;
      busy_hi[i] = 0;
    end

    // Reset values
    #2;
    check("rst_dout0", dout0, 8'h00);
    check("rst_pulses", {dv, pe, fe}, 9'h000);
    check("rst_busy", busy, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    check("held_low_busy", busy_hi[0], 0);
    check("held_low_events", evq.size(), 0);
    #1 rx_line[0] = 1'b1;
    repeat (5) @(posedge clk);

    // 1: N=16, 8N1, 0x55; valid visible after edge t0+152 (cycle t0+153)
    cpb[0] = 16'd16;
    bits = make_frame(9'h055, 8, 0, 1'b0, 1'b1, nb);
    drive(0, 16, bits, nb, 1'b1, t0);
    repeat (4) @(posedge clk);
    expect_ev("t1", 0, t0 + 152, 9'h055, 1'b1, 1'b0, 1'b0);
    check("t1_extra", evq.size(), 0);

    // 2: start glitch of 4 cycles, busy for 8 cycles, nothing else
    busy_hi[0] = 0;
    drive(0, 4, 32'h0, 1, 1'b1, t0);
    repeat (30) @(posedge clk);
    check("t2_busy_cycles", busy_hi[0], 8);
    check("t2_events", evq.size(), 0);
    check("t2_dout", dout0, 8'h55);

    // 3: 0xA3 with stop 0, line then held low for 100 cycles
    busy_hi[0] = 0;
    bits = make_frame(9'h0A3, 8, 0, 1'b0, 1'b0, nb);
    drive(0, 16, bits, nb, 1'b0, t0);
    repeat (100) @(posedge clk);
    expect_ev("t3", 0, t0 + 152, 9'h0A3, 1'b0, 1'b0, 1'b1);
    check("t3_extra", evq.size(), 0);
    check("t3_dout", dout0, 8'hA3);
    check("t3_busy_cycles", busy_hi[0], 152);
    #1 rx_line[0] = 1'b1;
    repeat (5) @(posedge clk);

    // 4: even parity, N=10, 0x07 with a wrong then a right parity bit
    cpb[1] = 16'd10;
    bits = make_frame(9'h007, 8, 1, 1'b0, 1'b1, nb);
    drive(1, 10, bits, nb, 1'b1, t0);
    repeat (4) @(posedge clk);
    expect_ev("t4_bad", 1, t0 + 5 + 10 * 10, 9'h007, 1'b1, 1'b1, 1'b0);
    bits = make_frame(9'h007, 8, 1, 1'b1, 1'b1, nb);
    drive(1, 10, bits, nb, 1'b1, t0);
    repeat (4) @(posedge clk);
    expect_ev("t4_good", 1, t0 + 5 + 10 * 10, 9'h007, 1'b1, 1'b0, 1'b0);

    // 5: N=8, back-to-back 0xA5 then 0x3C with no idle gap
    cpb[0] = 16'd8;
    bits  = make_frame(9'h0A5, 8, 0, 1'b0, 1'b1, nb);
    bits2 = make_frame(9'h03C, 8, 0, 1'b0, 1'b1, nb2);
    bits[31:10] = bits2[21:0];
    drive(0, 8, bits, 20, 1'b1, t0);
    repeat (4) @(posedge clk);
    expect_ev("t5_first", 0, t0 + 4 + 72, 9'h0A5, 1'b1, 1'b0, 1'b0);
    expect_ev("t5_second", 0, t0 + 80 + 4 + 72, 9'h03C, 1'b1, 1'b0, 1'b0);
    check("t5_extra", evq.size(), 0);

    // 6: reset during data bit 4 clears everything and discards the frame
    bits = make_frame(9'h05A, 8, 0, 1'b0, 1'b1, nb);
    fork
      drive(0, 8, bits, nb, 1'b1, t0);
      begin
        @(posedge clk);
        repeat (5 * 8 + 2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_dout", dout0, 8'h00);
        check("t6_pulses", {dv, pe, fe}, 9'h000);
        check("t6_busy", busy, 3'b000);
      end
    join
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("t6_no_events", evq.size(), 0);
    bits = make_frame(9'h0C9, 8, 0, 1'b0, 1'b1, nb);
    drive(0, 8, bits, nb, 1'b1, t0);
    repeat (4) @(posedge clk);
    expect_ev("t6_after", 0, t0 + 4 + 72, 9'h0C9, 1'b1, 1'b0, 1'b0);

    // Randomized frames on all three units; clocksPerBit is disturbed mid-frame.
    for (int k = 0; k < 30; k++) begin
      u    = $urandom_range(0, 2);
      n    = $urandom_range(1, 20);
      neff = (n < 4) ? 4 : n;
      db   = (u == 2) ? 7 : 8;
      pm   = u;
      dmask = (9'h1 << db) - 9'h1;
      data  = 9'($urandom) & dmask;
      good_par = (pm == 1) ? ^data : ~^data;
      par  = ($urandom_range(0, 3) == 0) ? ~good_par : good_par;
      stop = ($urandom_range(0, 6) != 0);
      bits = make_frame(data, db, pm, par, stop, nb);
      cpb[u] = 16'(n);
      fork
        drive(u, neff, bits, nb, 1'b1, t0b);
        begin
          repeat (neff + 2) @(posedge clk);
          #1 cpb[u] = 16'($urandom_range(0, 40));
        end
      join
      repeat (3) @(posedge clk);
      expect_ev($sformatf("rnd%0d", k), u, t0b + neff / 2 + (nb - 1) * neff, data,
                stop, stop && (pm != 0) && (par != good_par), !stop);
      check($sformatf("rnd%0d_extra", k), evq.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
